// File: rtl/fp32_to_int32_pipelined.sv
// Pipelined FP32 -> int32 converter: truncates toward zero and saturates on overflow.
// One operand per cycle, four register ranks give a fixed latency of three cycles after the sampling edge.
module fp32_to_int32_pipelined #(
    parameter bit SATURATE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_overflow
);

    typedef enum logic [1:0] {
        CLS_NORM   = 2'd0,
        CLS_ZERO   = 2'd1,
        CLS_MINNEG = 2'd2,
        CLS_OVF    = 2'd3
    } cls_t;

    logic        s1_valid;
    logic [31:0] s1_data;

    logic        s2_valid;
    logic        s2_sign;
    logic [31:0] s2_mag;
    cls_t        s2_cls;

    logic        s3_valid;
    logic [31:0] s3_data;
    logic        s3_ovf;

    logic [7:0]  c_exp;
    logic [22:0] c_frac;
    logic [31:0] c_full;
    logic        c_sign;
    logic [31:0] c_mag;
    cls_t        c_cls;

    assign c_exp  = s1_data[30:23];
    assign c_frac = s1_data[22:0];
    assign c_full = {8'd0, 1'b1, c_frac};

    // Classify the operand and align the hidden-bit mantissa to an integer magnitude.
    always_comb begin
        c_sign = s1_data[31];
        c_mag  = 32'd0;
        c_cls  = CLS_NORM;
        if (c_exp == 8'd0) begin
            c_cls = CLS_ZERO;
        end else if (c_exp == 8'd255) begin
            c_cls = CLS_OVF;
            if (c_frac != 23'd0) begin
                c_sign = 1'b0;
            end
        end else if (c_exp < 8'd127) begin
            c_cls = CLS_ZERO;
        end else if (c_exp <= 8'd157) begin
            if (c_exp >= 8'd150) begin
                c_mag = c_full << (c_exp - 8'd150);
            end else begin
                c_mag = c_full >> (8'd150 - c_exp);
            end
        end else if (c_exp == 8'd158 && s1_data[31] && c_frac == 23'd0) begin
            c_cls = CLS_MINNEG;
        end else begin
            c_cls = CLS_OVF;
        end
    end

    logic [31:0] r_data;
    logic        r_ovf;

    // Apply the sign, or pick the saturation value for unrepresentable operands.
    always_comb begin
        r_data = 32'd0;
        r_ovf  = 1'b0;
        case (s2_cls)
            CLS_NORM:   r_data = s2_sign ? (~s2_mag + 32'd1) : s2_mag;
            CLS_ZERO:   r_data = 32'd0;
            CLS_MINNEG: r_data = 32'h8000_0000;
            CLS_OVF: begin
                r_ovf  = 1'b1;
                r_data = (SATURATE && !s2_sign) ? 32'h7FFF_FFFF : 32'h8000_0000;
            end
            default:    r_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s1_data      <= 32'd0;
            s2_valid     <= 1'b0;
            s2_sign      <= 1'b0;
            s2_mag       <= 32'd0;
            s2_cls       <= CLS_ZERO;
            s3_valid     <= 1'b0;
            s3_data      <= 32'd0;
            s3_ovf       <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= 32'd0;
            out_overflow <= 1'b0;
        end else begin
            s1_valid     <= in_valid;
            s1_data      <= in_data;
            s2_valid     <= s1_valid;
            s2_sign      <= c_sign;
            s2_mag       <= c_mag;
            s2_cls       <= c_cls;
            s3_valid     <= s2_valid;
            s3_data      <= r_data;
            s3_ovf       <= r_ovf;
            out_valid    <= s3_valid;
            out_data     <= s3_data;
            out_overflow <= s3_ovf;
        end
    end

endmodule

// File: doc/fp32_to_int32_pipelined.md
Name: fp32_to_int32_pipelined

Overview:
- Three-stage pipelined converter from IEEE-754 FP32 to signed 32-bit two's-complement integer.
- Rounds toward zero (truncation) and saturates on overflow.
- Performs the opposite conversion to the FP32 datapath blocks: it turns adder/multiplier results back into integers for the Zedboard host and test logic.
- Accepts one operand per cycle with no backpressure.

Parameters:
- SATURATE, 1, overflow value select. 1: positive overflow and NaN give 0x7FFFFFFF, negative overflow gives 0x80000000. 0: every overflow/NaN gives 0x80000000.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  32  FP32 operand: [31] sign, [30:23] biased exponent, [22:0] mantissa.
- out_valid  output  1  out_data and out_overflow are valid this cycle.
- out_data  output  32  signed int32 result.
- out_overflow  output  1  operand was not representable (too large, Inf or NaN).

Behaviour:
- Single clock domain.
- Reset is asynchronous and active-high: all pipeline registers clear immediately, and out_valid, out_data and out_overflow all read 0.
- Reset mid-stream discards every in-flight operand. No out_valid pulse is produced for operands accepted before reset.
- Latency is exactly 3 cycles. An operand sampled with in_valid=1 at edge N appears with out_valid=1 after edge N+3.
- Throughput is 1 per cycle, with no bubbles and no stall input. The valid bit travels alongside the data through all stages.
- Data registers load every cycle regardless of valid. Only the out_valid qualifier is meaningful.
- Stage 1: register in_valid and in_data.
- Stage 2: classify and shift, then register sign, 32-bit magnitude, a zero/overflow class, and valid. With e = [30:23] and E = e - 127:
  - e == 0 (zero or subnormal): magnitude 0, class ZERO.
  - e == 255 (Inf or NaN): class OVF. NaN is treated as positive.
  - e < 127 (|x| < 1): magnitude 0, no overflow. This covers -0.5 → 0.
  - 127 <= e <= 157 (E = 0..30): mag = {1, m}. Shift left by E-23 when E >= 23, otherwise right by 23-E. Truncate shifted-out bits.
  - e == 158, sign=1, m == 0: exactly -2^31, class MINNEG. Output 0x80000000, no overflow.
  - e >= 158 otherwise: class OVF.
- Stage 3: produce the output.
  - Normal case: out_data = sign ? (~mag + 1) : mag. A negated zero must be 0x00000000.
  - OVF: out_overflow=1 and out_data is set per SATURATE. When NaN and SATURATE=1, the output is 0x7FFFFFFF.
  - out_overflow is 0 for every non-OVF class.
- All width arithmetic is unsigned 32-bit on the magnitude. The shift amount is at most 23 in either direction, so no bits are lost left of bit 30.

Test Plan:
- Basic values, in_valid pulsed once each → 3 cycles later:
  - 0x3F800000 (1.0) → 0x00000001, ovf 0.
  - 0xC0200000 (-2.5) → 0xFFFFFFFE, ovf 0.
  - 0x47F12000 (123456.0) → 0x0001E240, ovf 0.
- Fractions and zeros, all → 0x00000000, ovf 0:
  - 0x3F400000 (0.75).
  - 0xBF000000 (-0.5).
  - 0x80000000 (-0.0).
  - 0x00000001 (subnormal).
- Boundaries:
  - 0x4EFFFFFF (2147483520) → 0x7FFFFF80, ovf 0.
  - 0xCF000000 (-2^31) → 0x80000000, ovf 0.
  - 0x4F000000 (2^31) → 0x7FFFFFFF, ovf 1.
  - 0xCF000001 → 0x80000000, ovf 1.
- Specials, SATURATE=1:
  - 0x7FC00000 (NaN) → 0x7FFFFFFF, ovf 1.
  - 0xFF800000 (-Inf) → 0x80000000, ovf 1.
  - Rerun NaN with SATURATE=0 → 0x80000000, ovf 1.
- Streaming: 8 back-to-back operands with in_valid high, then a 2-cycle gap, then 3 more → outputs in order, out_valid high for exactly those 11 cycles, with the gap reproduced 3 cycles later. Check against a reference model using truncating casts.
- Reset mid-stream: assert reset asynchronously (between edges) while 3 operands are in flight → out_valid, out_data and out_overflow drop to 0 immediately. After release, no stale outputs appear. The next operand 0x40400000 (3.0) → 0x00000003 after exactly 3 cycles.
